// File: rtl/bus_pkg.sv
// Shared types, defaults and helpers for the N-master shared bus.
package bus_pkg;

    localparam int unsigned DEF_N_MASTER = 2;
    localparam int unsigned DEF_N_SLAVE  = 4;
    localparam int unsigned DEF_AW       = 8;
    localparam int unsigned DEF_DW       = 32;
    localparam int unsigned DEF_SW       = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Ceiling log2, used for index widths at elaboration time.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with grant hold: the owner keeps the bus while it requests.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned N_MASTER = DEF_N_MASTER
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] grant
);

    localparam int unsigned IW = (N_MASTER > 1) ? clog2(N_MASTER) : 1;
    localparam int unsigned CW = IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_MASTER - 1);

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [IW-1:0] base;
    logic [IW-1:0] pick;
    logic [CW-1:0] cand;
    logic          found;
    logic          owner_req;

    // First requester strictly after base, wrapping; base is the owner when
    // handing over and the last-served master when idle.
    always_comb begin
        base      = (state == ST_OWN) ? owner : last;
        owner_req = |(req & grant);
        pick      = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= N_MASTER; off++) begin
            cand = {1'b0, base} + CW'(off);
            if (cand >= CW'(N_MASTER)) cand = cand - CW'(N_MASTER);
            for (int unsigned i = 0; i < N_MASTER; i++) begin
                if (!found && req[i] && (cand == CW'(i))) begin
                    found = 1'b1;
                    pick  = IW'(i);
                end
            end
        end
    end

    // Arbiter FSM with registered one-hot grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= LAST_IDX;
            grant <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_OWN;
                        owner <= pick;
                        grant <= N_MASTER'(1) << pick;
                    end
                end
                ST_OWN: begin
                    if (!owner_req) begin
                        last <= owner;
                        if (found) begin
                            owner <= pick;
                            grant <= N_MASTER'(1) << pick;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/bus_nxm.sv
// Shared bus: N masters arbitrated onto one slave port with upper-address decode
// and a registered one-cycle read return.
module bus_nxm
    import bus_pkg::*;
#(
    parameter int unsigned N_MASTER = DEF_N_MASTER,
    parameter int unsigned N_SLAVE  = DEF_N_SLAVE,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned SW       = DEF_SW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_MASTER-1:0]    M_req,
    input  logic [N_MASTER-1:0]    M_wr,
    input  logic [N_MASTER*AW-1:0] M_addr,
    input  logic [N_MASTER*DW-1:0] M_dout,
    input  logic [N_SLAVE*DW-1:0]  S_dout,
    output logic [N_MASTER-1:0]    M_grant,
    output logic [DW-1:0]          M_din,
    output logic                   M_rvalid,
    output logic                   M_err,
    output logic [N_SLAVE-1:0]     S_sel,
    output logic                   S_wr,
    output logic [AW-1:0]          S_addr,
    output logic [DW-1:0]          S_din
);

    logic [N_MASTER-1:0] xfer_vec;
    logic                xfer;
    logic [AW-1:0]       own_addr;
    logic [DW-1:0]       own_dout;
    logic                own_wr;
    logic [SW-1:0]       idx;
    logic                idx_ok;
    logic                hit;
    logic                miss;
    logic [SW-1:0]       sel_q;

    bus_rr_arbiter #(
        .N_MASTER (N_MASTER)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (M_req),
        .grant   (M_grant)
    );

    // Owner mux and slave decode; everything is zero outside a transfer cycle.
    always_comb begin
        xfer_vec = M_grant & M_req;
        xfer     = |xfer_vec;
        own_addr = '0;
        own_dout = '0;
        own_wr   = 1'b0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            if (xfer_vec[i]) begin
                own_addr = own_addr | M_addr[i*AW +: AW];
                own_dout = own_dout | M_dout[i*DW +: DW];
                own_wr   = own_wr | M_wr[i];
            end
        end
        idx    = own_addr[AW-1 -: SW];
        idx_ok = (32'(idx) < N_SLAVE);
        hit    = xfer && idx_ok;
        miss   = xfer && !idx_ok;
        S_addr = own_addr;
        S_din  = own_dout;
        S_wr   = own_wr && hit;
        S_sel  = '0;
        for (int unsigned j = 0; j < N_SLAVE; j++) begin
            S_sel[j] = hit && (idx == SW'(j));
        end
    end

    // Read-return and decode-error strobes, one cycle after the transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            M_rvalid <= 1'b0;
            M_err    <= 1'b0;
            sel_q    <= '0;
        end else begin
            M_rvalid <= hit && !own_wr;
            M_err    <= miss;
            if (hit && !own_wr) sel_q <= idx;
        end
    end

    // Broadcast the selected slave's read data only while it is valid.
    always_comb begin
        M_din = '0;
        for (int unsigned j = 0; j < N_SLAVE; j++) begin
            if (M_rvalid && (sel_q == SW'(j))) M_din = S_dout[j*DW +: DW];
        end
    end

endmodule

// File: tb/tb_bus_nxm.sv
// Directed bench: default 2x4 bus plus a 3-master / 3-slave instance.
module tb_bus_nxm;

    logic clk;
    int   total;
    int   bad;

    // Instance A: N_MASTER=2, N_SLAVE=4
    logic        a_rst;
    logic [1:0]  a_req, a_wr;
    logic [15:0] a_addr;
    logic [63:0] a_mdout;
    logic [127:0] a_sdout;
    logic [1:0]  a_grant;
    logic [31:0] a_din, a_sdin;
    logic        a_rvalid, a_err, a_swr;
    logic [3:0]  a_sel;
    logic [7:0]  a_saddr;

    // Instance B: N_MASTER=3, N_SLAVE=3
    logic        b_rst;
    logic [2:0]  b_req, b_wr;
    logic [23:0] b_addr;
    logic [95:0] b_mdout;
    logic [95:0] b_sdout;
    logic [2:0]  b_grant;
    logic [31:0] b_din, b_sdin;
    logic        b_rvalid, b_err, b_swr;
    logic [2:0]  b_sel;
    logic [7:0]  b_saddr;

    bus_nxm #(.N_MASTER(2), .N_SLAVE(4), .AW(8), .DW(32), .SW(2)) dut_a (
        .clk(clk), .reset_n(a_rst), .M_req(a_req), .M_wr(a_wr), .M_addr(a_addr),
        .M_dout(a_mdout), .S_dout(a_sdout), .M_grant(a_grant), .M_din(a_din),
        .M_rvalid(a_rvalid), .M_err(a_err), .S_sel(a_sel), .S_wr(a_swr),
        .S_addr(a_saddr), .S_din(a_sdin)
    );

    bus_nxm #(.N_MASTER(3), .N_SLAVE(3), .AW(8), .DW(32), .SW(2)) dut_b (
        .clk(clk), .reset_n(b_rst), .M_req(b_req), .M_wr(b_wr), .M_addr(b_addr),
        .M_dout(b_mdout), .S_dout(b_sdout), .M_grant(b_grant), .M_din(b_din),
        .M_rvalid(b_rvalid), .M_err(b_err), .S_sel(b_sel), .S_wr(b_swr),
        .S_addr(b_saddr), .S_din(b_sdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        a_rst = 1'b0; b_rst = 1'b0;
        a_req = 2'b11; a_wr = '0; a_addr = '0; a_mdout = '0;
        b_req = '0; b_wr = '0; b_addr = '0; b_mdout = '0;
        a_sdout = {32'hD3D33333, 32'h12345678, 32'hB1B11111, 32'hA0A00000};
        b_sdout = {32'h33334444, 32'h11112222, 32'h00001000};
        next_edge; next_edge; mid;
        total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", a_grant); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", a_rvalid); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", a_err); end
        total++; if (a_sel !== 4'b0000) begin bad++; $display("FAIL rst_sel got=%b exp=0000", a_sel); end
        total++; if (b_grant !== 3'b000) begin bad++; $display("FAIL rst_b_grant got=%b exp=000", b_grant); end
        next_edge;
        a_rst = 1'b1; b_rst = 1'b1;
        mid;
        total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL rel_grant0 got=%b exp=00", a_grant); end
        next_edge; mid;
        total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL rel_grant1 got=%b exp=01", a_grant); end
    endtask

    task automatic test_write_decode;
        a_wr = 2'b01; a_addr[7:0] = 8'h45; a_mdout[31:0] = 32'hDEADBEEF;
        #1;
        total++; if (a_sel !== 4'b0010) begin bad++; $display("FAIL wr_sel45 got=%b exp=0010", a_sel); end
        total++; if (a_swr !== 1'b1) begin bad++; $display("FAIL wr_swr got=%b exp=1", a_swr); end
        total++; if (a_sdin !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_sdin got=%h exp=deadbeef", a_sdin); end
        total++; if (a_saddr !== 8'h45) begin bad++; $display("FAIL wr_saddr got=%h exp=45", a_saddr); end
        next_edge;
        a_addr[7:0] = 8'hC3;
        mid;
        total++; if (a_sel !== 4'b1000) begin bad++; $display("FAIL wr_selC3 got=%b exp=1000", a_sel); end
        total++; if (a_swr !== 1'b1) begin bad++; $display("FAIL wr_swr2 got=%b exp=1", a_swr); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL wr_rvalid got=%b exp=0", a_rvalid); end
        total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL wr_hold got=%b exp=01", a_grant); end
    endtask

    task automatic test_read_latency;
        next_edge;
        a_wr = 2'b00; a_addr[7:0] = 8'h80;
        mid;
        total++; if (a_sel !== 4'b0100) begin bad++; $display("FAIL rd_sel80 got=%b exp=0100", a_sel); end
        total++; if (a_swr !== 1'b0) begin bad++; $display("FAIL rd_swr got=%b exp=0", a_swr); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_early got=%b exp=0", a_rvalid); end
        next_edge;
        a_addr[7:0] = 8'h00;
        mid;
        total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid1 got=%b exp=1", a_rvalid); end
        total++; if (a_din !== 32'h12345678) begin bad++; $display("FAIL rd_din2 got=%h exp=12345678", a_din); end
        next_edge;
        a_addr[7:0] = 8'h40;
        mid;
        total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid0 got=%b exp=1", a_rvalid); end
        total++; if (a_din !== 32'hA0A00000) begin bad++; $display("FAIL b2b_din0 got=%h exp=a0a00000", a_din); end
        next_edge;
        a_req = 2'b10;
        mid;
        total++; if (a_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid1 got=%b exp=1", a_rvalid); end
        total++; if (a_din !== 32'hB1B11111) begin bad++; $display("FAIL b2b_din1 got=%h exp=b1b11111", a_din); end
        total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL drop_grant got=%b exp=01", a_grant); end
        total++; if (a_sel !== 4'b0000) begin bad++; $display("FAIL idle_sel got=%b exp=0000", a_sel); end
        total++; if (a_sdin !== 32'h0) begin bad++; $display("FAIL idle_sdin got=%h exp=0", a_sdin); end
    endtask

    task automatic test_handover;
        next_edge;
        a_addr[15:8] = 8'hC3; a_wr = 2'b00;
        mid;
        total++; if (a_grant !== 2'b10) begin bad++; $display("FAIL ho_grant got=%b exp=10", a_grant); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL ho_rvalid got=%b exp=0", a_rvalid); end
        total++; if (a_saddr !== 8'hC3) begin bad++; $display("FAIL ho_saddr got=%h exp=c3", a_saddr); end
        total++; if (a_sel !== 4'b1000) begin bad++; $display("FAIL ho_sel got=%b exp=1000", a_sel); end
        next_edge;
        a_req = 2'b00;
        mid;
        total++; if (a_din !== 32'hD3D33333) begin bad++; $display("FAIL ho_din got=%h exp=d3d33333", a_din); end
        next_edge; mid;
        total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL ho_idle got=%b exp=00", a_grant); end
        total++; if (a_din !== 32'h0) begin bad++; $display("FAIL ho_din0 got=%h exp=0", a_din); end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_g [9];
        logic [2:0] req_after [9];
        exp_g     = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b000, 3'b001};
        req_after = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b000, 3'b001, 3'b001};
        next_edge;
        b_req = 3'b111;
        mid;
        total++; if (b_grant !== 3'b000) begin bad++; $display("FAIL rr_start got=%b exp=000", b_grant); end
        for (int i = 0; i < 9; i++) begin
            next_edge;
            b_req = req_after[i];
            mid;
            total++;
            if (b_grant !== exp_g[i]) begin
                bad++; $display("FAIL rr_step%0d got=%b exp=%b", i, b_grant, exp_g[i]);
            end
        end
    endtask

    task automatic test_decode_error;
        b_wr = 3'b000; b_addr[7:0] = 8'hC0;
        #1;
        total++; if (b_sel !== 3'b000) begin bad++; $display("FAIL de_sel got=%b exp=000", b_sel); end
        total++; if (b_swr !== 1'b0) begin bad++; $display("FAIL de_swr got=%b exp=0", b_swr); end
        next_edge;
        b_addr[7:0] = 8'h40;
        mid;
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL de_err got=%b exp=1", b_err); end
        total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL de_rvalid got=%b exp=0", b_rvalid); end
        total++; if (b_din !== 32'h0) begin bad++; $display("FAIL de_din got=%h exp=0", b_din); end
        total++; if (b_sel !== 3'b010) begin bad++; $display("FAIL de_sel40 got=%b exp=010", b_sel); end
        next_edge; mid;
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL de_err_clr got=%b exp=0", b_err); end
        total++; if (b_rvalid !== 1'b1) begin bad++; $display("FAIL de_rd_rvalid got=%b exp=1", b_rvalid); end
        total++; if (b_din !== 32'h11112222) begin bad++; $display("FAIL de_rd_din got=%h exp=11112222", b_din); end
    endtask

    task automatic test_reset_mid_read;
        b_rst = 1'b0;
        next_edge; mid;
        total++; if (b_grant !== 3'b000) begin bad++; $display("FAIL mr_grant got=%b exp=000", b_grant); end
        total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL mr_rvalid got=%b exp=0", b_rvalid); end
        total++; if (b_din !== 32'h0) begin bad++; $display("FAIL mr_din got=%h exp=0", b_din); end
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL mr_err got=%b exp=0", b_err); end
        b_rst = 1'b1; b_req = 3'b000;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_write_decode;
        test_read_latency;
        test_handover;
        test_round_robin;
        test_decode_error;
        test_reset_mid_read;
        next_edge;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_nxm.md
Name: bus_nxm

Overview:
- Parametrised shared bus: N_MASTER masters, one common slave port, N_SLAVE slave selects.
- Round-robin arbiter with grant hold (locked bursts) and upper-address slave decode.
- Registered read-data return, with a read-valid strobe and a decode-error strobe.
- Sits between processor/DMA masters and memory/peripheral slaves. Successor to the single-master, two-slave bus.

Parameters:
- N_MASTER, 2, number of masters (1..8)
- N_SLAVE, 4, number of slaves (1..2^SW)
- AW, 8, address width
- DW, 32, data width
- SW, 2, slave-index width; slave index = addr[AW-1:AW-SW]

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- M_req  in  N_MASTER  per-master request
- M_wr  in  N_MASTER  per-master write enable (1 = write, 0 = read)
- M_addr  in  N_MASTER*AW  packed master addresses, master i at [i*AW +: AW]
- M_dout  in  N_MASTER*DW  packed master write data
- S_dout  in  N_SLAVE*DW  packed slave read data, slave j at [j*DW +: DW]
- M_grant  out  N_MASTER  one-hot grant (registered)
- M_din  out  DW  read data broadcast to all masters
- M_rvalid  out  1  M_din valid (registered)
- M_err  out  1  decode error for previous granted transfer (registered)
- S_sel  out  N_SLAVE  one-hot slave select
- S_wr  out  1  slave write enable
- S_addr  out  AW  slave address
- S_din  out  DW  slave write data

Behaviour:
- Reset: with reset_n low at a rising edge, the following are 0:
  - M_grant, M_rvalid, M_err
  - internal owner-valid and registered read-select
  - round-robin pointer (last-served = N_MASTER-1, so master 0 has top priority first)
- Reset is not async; before the first edge, outputs are undefined.
- Arbiter FSM, two states:
  - IDLE (no owner).
  - OWN (owner k, M_grant[k] = 1).
- IDLE transitions:
  - If any M_req is high, grant the first requester searching from (last+1) mod N_MASTER upward, wrapping. Enter OWN next edge.
  - So the grant latency from req is 1 cycle.
- OWN transitions:
  - While M_req[k] stays high, the grant is held regardless of other requests (locked transfer).
  - At an edge where M_req[k] is low, last = k.
  - If any other master requests, grant it in the same edge (zero dead cycles), searching from k+1.
  - Otherwise go to IDLE.
  - If only k re-requests, it is served again after one IDLE cycle.
- Transfer cycle: M_grant[k] and M_req[k] both high.
- Slave-side path (combinational from the owner's signals):
  - S_addr = M_addr[k], S_din = M_dout[k], S_wr = M_wr[k].
  - S_sel[idx] = 1 with idx = S_addr[AW-1:AW-SW], only if idx < N_SLAVE.
- Outside a transfer cycle: S_sel = 0, S_wr = 0, S_addr = 0, S_din = 0.
- Decode miss (idx >= N_SLAVE) during a transfer:
  - S_sel = 0, S_wr forced 0.
  - M_err = 1 on the next cycle, for one cycle per missed transfer.
- Read return, 1-cycle latency (slaves have synchronous read):
  - On each read transfer (wr = 0, valid idx), register sel_q = idx and set M_rvalid = 1 for the next cycle.
  - M_din = S_dout[sel_q] when M_rvalid is high, else 0.
- Writes and misses: M_rvalid = 0; a decode-error read returns M_din = 0.
- Back-to-back reads: M_rvalid stays high continuously; sel_q updates every cycle.
- Grant handover to a new master:
  - The pending read of the old owner still returns its data in the handover cycle.
  - Masters qualify M_din by their own outstanding read.
- Reset mid-transfer: grant drops at that edge, and the pending M_rvalid/M_err are cleared.
- N_MASTER = 1: degenerate case, grant follows req with 1-cycle latency.

Decomposition:
- Package bus_pkg:
  - clog2 function
  - arbiter state encoding (ST_IDLE = 1'b0, ST_OWN = 1'b1)
  - default widths.
- Sub-module bus_rr_arbiter(clk, reset_n, req, grant):
  - holds the FSM and the round-robin pointer
  - parametrised by N_MASTER.
- Top level: decode, muxing and the read-return registers.

Test Plan:
- Reset/idle: reset_n = 0 for 2 cycles with M_req = 2'b11 -> M_grant = 0, M_rvalid = 0, S_sel = 0. After release, M_grant = 2'b01 one cycle later.
- Write decode:
  - Stimulus: master 0 holds req; writes 0xDEADBEEF to addr 0x45, then 0xC3.
  - Expect S_sel = 4'b0010 then 4'b1000, S_wr = 1, S_din = 0xDEADBEEF.
  - Expect M_rvalid = 0.
- Read latency:
  - Stimulus: read addr 0x80 with S_dout[2] = 0x12345678.
  - Expect M_rvalid = 1 and M_din = 0x12345678 exactly one cycle after the transfer cycle.
  - Back-to-back reads of 0x00/0x40 return S_dout[0]/S_dout[1] on consecutive cycles.
- Round-robin fairness:
  - Stimulus: N_MASTER = 3, all requesting, each owner drops req after 2 cycles.
  - Expect grant order 0, 1, 2, 0 with no idle cycle between owners.
  - A lone re-request by the same master gets one IDLE cycle.
- Decode error:
  - Stimulus: N_SLAVE = 3, read at 0xC0.
  - Expect S_sel = 0, S_wr = 0; next cycle M_err = 1, M_rvalid = 0, M_din = 0.
- Reset mid-read: assert reset_n = 0 in the cycle after a read transfer -> M_rvalid and M_grant are 0 at that edge, and no stale data on M_din.
